// File: rtl/ibex_obi_wb_bridge.sv
// Ibex OBI memory port to pipelined Wishbone B4 master, in-order responses.
// Optional hung-slave flush to OBI errors: define IBEX_WB_TIMEOUT_EN.
module ibex_obi_wb_bridge #(
    parameter int unsigned AW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_i,
    output logic          gnt_o,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic          rvalid_o,
    output logic [31:0]   rdata_o,
    output logic          err_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [AW-3:0] wb_adr_o,
    output logic [31:0]   wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    input  logic          wb_stall_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic [31:0]   wb_dat_i,
    output logic          protocol_err_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 ||
        TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ibex_obi_wb_bridge: parameter out of range");
    end

`ifdef IBEX_WB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_e;
`else
    typedef enum logic [1:0] {IDLE, ACTIVE} state_e;
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_flush;
    logic          rsp_in;
    logic          rsp_ok;
    logic          rsp_flush;
    logic          spurious;
    logic          room;
    logic          unused_addr;

    assign unused_addr = ^addr_i[1:0];

`ifdef IBEX_WB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q;
    logic          tmo_fire;

    assign in_flush  = (state_q == FLUSH);
    assign rsp_flush = in_flush && (count_q != '0);
    assign tmo_fire  = (state_q == ACTIVE) && !rsp_in && (tmo_q == TMO_LAST);

    // Counts only idle cycles spent waiting in ACTIVE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else if (state_q == ACTIVE && !rsp_in && state_d == ACTIVE) begin
            tmo_q <= tmo_q + 1'b1;
        end else begin
            tmo_q <= '0;
        end
    end
`else
    assign in_flush  = 1'b0;
    assign rsp_flush = 1'b0;
`endif

    assign rsp_in   = wb_ack_i || wb_err_i;
    assign rsp_ok   = rsp_in && (count_q != '0) && !in_flush;
    assign spurious = rsp_in && (count_q == '0) && !in_flush;

    assign room     = (count_q < MAX_CNT) && !in_flush;
    assign wb_stb_o = req_i && room;
    assign gnt_o    = wb_stb_o && !wb_stall_i;
    assign wb_cyc_o = wb_stb_o || ((count_q != '0) && !in_flush);

    assign wb_adr_o = addr_i[AW-1:2];
    assign wb_dat_o = wdata_i;
    assign wb_sel_o = be_i;
    assign wb_we_o  = we_i;

    always_comb begin
        count_d = count_q;
        state_d = state_q;
        if (rsp_flush) begin
            count_d = count_q - 1'b1;
        end else if (gnt_o && !rsp_ok) begin
            count_d = count_q + 1'b1;
        end else if (!gnt_o && rsp_ok) begin
            count_d = count_q - 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (gnt_o) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (count_d == '0) begin
                    state_d = IDLE;
`ifdef IBEX_WB_TIMEOUT_EN
                end else if (tmo_fire) begin
                    state_d = FLUSH;
`endif
                end
            end
`ifdef IBEX_WB_TIMEOUT_EN
            FLUSH: begin
                if (count_d == '0) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Error wins over ack; rdata_o keeps its last value between responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o       <= 1'b0;
            err_o          <= 1'b0;
            rdata_o        <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            rvalid_o <= rsp_ok || rsp_flush;
            if (rsp_flush) begin
                err_o   <= 1'b1;
                rdata_o <= '0;
            end else if (rsp_ok) begin
                err_o   <= wb_err_i;
                rdata_o <= wb_err_i ? 32'h0 : wb_dat_i;
            end else begin
                err_o <= 1'b0;
            end
            if (spurious) protocol_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ibex_obi_wb_bridge.sv
// Scoreboard bench for ibex_obi_wb_bridge: a reference counter predicts
// grants and responses; expected responses are queued and popped on rvalid.
module tb_ibex_obi_wb_bridge;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        gnt;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'hf;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        cyc_o;
    logic        stb;
    logic [29:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        wbwe;
    logic        stall = 1'b0;
    logic        ack = 1'b0;
    logic        werr = 1'b0;
    logic [31:0] rdat = '0;
    logic        perr;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b1;

    int          mcnt;
    bit          exp_rv;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    ibex_obi_wb_bridge #(
        .AW(32), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata),
        .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .wb_cyc_o(cyc_o), .wb_stb_o(stb), .wb_adr_o(adr),
        .wb_dat_o(wdat), .wb_sel_o(sel), .wb_we_o(wbwe),
        .wb_stall_i(stall), .wb_ack_i(ack), .wb_err_i(werr),
        .wb_dat_i(rdat), .protocol_err_o(perr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model of the outstanding counter and response stream.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt = 0;
            exp_rv = 1'b0;
            sb.delete();
        end else begin
            bit mg, mr;
            mg = req && (mcnt < MAXO) && !stall;
            mr = (ack || werr) && (mcnt != 0);
            if (mr) sb.push_back(werr ? {1'b1, 32'h0} : {1'b0, rdat});
            exp_rv = mr;
            mcnt = mcnt + int'(mg) - int'(mr);
        end
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("rvalid", rvalid, exp_rv);
            chk("gnt", gnt, req && (mcnt < MAXO) && !stall);
            chk("stb", stb, req && (mcnt < MAXO));
            if (rvalid) begin
                if (sb.size() == 0) begin
                    chk("sb_underrun", 1, 0);
                end else begin
                    logic [32:0] e;
                    e = sb.pop_front();
                    chk("rdata", rdata, e[31:0]);
                    chk("err", err, e[32]);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req = 0; ack = 0; werr = 0; stall = 0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    task automatic ack_pulse(input logic [31:0] d, input logic e);
        ack = ~e; werr = e; rdat = d;
        cyc();
        ack = 0; werr = 0;
    endtask

    initial begin
        #2;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_cyc", cyc_o, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_perr", perr, 0);
        do_reset();

        // single read
        req = 1; addr = 32'h0000_1004; we = 0; be = 4'hf;
        @(negedge clk);
        chk("adr", adr, 32'h401);
        cyc();
        req = 0;
        repeat (3) begin
            @(negedge clk);
            chk("cyc_hold", cyc_o, 1);
            cyc();
        end
        ack_pulse(32'hDEAD_BEEF, 0);
        repeat (2) cyc();

        // back-to-back, limit of two outstanding
        req = 1; addr = 32'h100; cyc();
        addr = 32'h104; cyc();
        addr = 32'h108;
        repeat (2) begin
            @(negedge clk);
            chk("full_stb", stb, 0);
            cyc();
        end
        ack_pulse(32'h11, 0);
        @(negedge clk);
        chk("third_gnt", gnt, 1);
        cyc();
        req = 0;
        ack_pulse(32'h22, 0);
        cyc();
        ack_pulse(32'h33, 0);
        repeat (2) cyc();

        // stalled write
        req = 1; we = 1; be = 4'b0011; wdata = 32'hCAFE_F00D;
        addr = 32'h200; stall = 1;
        repeat (4) begin
            @(negedge clk);
            chk("stall_gnt", gnt, 0);
            chk("stall_sel", sel, 4'b0011);
            cyc();
        end
        stall = 0;
        @(negedge clk);
        chk("unstall_gnt", gnt, 1);
        chk("wdat", wdat, 32'hCAFE_F00D);
        cyc();
        req = 0; we = 0;
        @(negedge clk);
        chk("cnt_one", cyc_o, 1);
        cyc();
        ack_pulse(32'h0, 0);
        cyc();

        // error then normal read, then ack+err together
        req = 1; cyc(); req = 0;
        ack_pulse(32'hFFFF_FFFF, 1);
        req = 1; cyc(); req = 0;
        ack_pulse(32'h1234_5678, 0);
        req = 1; cyc(); req = 0;
        ack = 1; werr = 1; rdat = 32'h55;
        cyc();
        ack = 0; werr = 0;
        repeat (2) cyc();

        // reset with a request in flight
        req = 1; cyc(); req = 0;
        rst_n = 0;
        @(negedge clk);
        chk("mid_rst_cyc", cyc_o, 0);
        chk("mid_rst_rv", rvalid, 0);
        cyc();
        rst_n = 1;
        cyc();

        // spurious ack with nothing outstanding
        ack_pulse(32'h77, 0);
        repeat (3) begin
            @(negedge clk);
            chk("perr_sticky", perr, 1);
            cyc();
        end
        chk("sb_empty", sb.size(), 0);
        do_reset();
        @(negedge clk);
        chk("perr_clr", perr, 0);
        cyc();

`ifdef IBEX_WB_TIMEOUT_EN
        begin
            int n;
            mon_en = 0;
            req = 1; cyc(); cyc(); req = 0;
            n = 1;
            while (cyc_o && n < 40) begin
                cyc();
                n++;
            end
            chk("tmo_cycle", n, 16);
            repeat (2) begin
                cyc();
                chk("flush_rv", rvalid, 1);
                chk("flush_err", err, 1);
                chk("flush_rdata", rdata, 0);
            end
            cyc();
            chk("flush_done", rvalid, 0);
            req = 1;
            @(negedge clk);
            chk("post_flush_gnt", gnt, 1);
            cyc();
            req = 0;
            do_reset();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ibex_obi_wb_bridge.md
Name: ibex_obi_wb_bridge

Overview:
- Parametrised bridge from one Ibex OBI-style memory port (instruction or data) to a pipelined Wishbone B4 master.
- Supports a configurable number of outstanding transactions, tracked by a counter, and returns responses in order with one-cycle latency.
- One instance sits behind each Ibex memory port, between the CPU top and the system crossbar.
- An optional bus-timeout flush turns a hung slave into OBI error responses instead of a CPU lockup.

Parameters:
- AW, 32, byte address width; Wishbone address is word-aligned, AW-2 bits.
- MAX_OUTSTANDING, 2, maximum number of accepted but unanswered requests (1..15).
- TIMEOUT_CYCLES, 1024, idle-response cycles before a timeout; only used with IBEX_WB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  OBI request
- gnt_o  out  1  OBI grant
- addr_i  in  AW  OBI byte address
- we_i  in  1  OBI write enable
- be_i  in  4  OBI byte enables
- wdata_i  in  32  OBI write data
- rvalid_o  out  1  OBI response valid
- rdata_o  out  32  OBI read data
- err_o  out  1  OBI response error (valid with rvalid_o)
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_adr_o  out  AW-2  Wishbone word address, addr_i[AW-1:2]
- wb_dat_o  out  32  Wishbone write data
- wb_sel_o  out  4  Wishbone byte select
- wb_we_o  out  1  Wishbone write enable
- wb_stall_i  in  1  Wishbone stall
- wb_ack_i  in  1  Wishbone ack
- wb_err_i  in  1  Wishbone error
- wb_dat_i  in  32  Wishbone read data
- protocol_err_o  out  1  sticky flag: response received with nothing outstanding

Behaviour:
- Reset values: all outputs 0; outstanding count = 0; state IDLE.
- States:
  - IDLE: count = 0.
  - ACTIVE: count > 0.
  - FLUSH: only with the optional feature.
- Request path, combinational: room = (count < MAX_OUTSTANDING) && state != FLUSH.
  - wb_stb_o = req_i && room.
  - gnt_o = wb_stb_o && !wb_stall_i.
  - wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o pass through from addr_i, wdata_i, be_i, we_i.
- wb_cyc_o = wb_stb_o || (count != 0 && state != FLUSH).
- Counter:
  - +1 on gnt_o.
  - -1 on (wb_ack_i || wb_err_i) with count != 0.
  - Both in the same cycle: count unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows.
- Response path, registered, latency exactly 1 cycle:
  - rvalid_o <= (wb_ack_i || wb_err_i) && count != 0.
  - err_o <= wb_err_i.
  - rdata_o <= wb_dat_i on ack, 0 on err.
  - rdata_o holds its value when rvalid_o = 0.
- ack and err asserted together: treated as err.
- Spurious ack/err while count = 0: ignored (no rvalid_o, no decrement); protocol_err_o set to 1, cleared only by reset.
- Transitions:
  - IDLE->ACTIVE on gnt_o.
  - ACTIVE->IDLE when the count reaches 0.
  - A same-cycle grant plus response at count 1 stays in ACTIVE.
- Reset mid-transaction: count and state cleared immediately; no responses for lost requests.

Optional Feature:
- Macro: IBEX_WB_TIMEOUT_EN.
- Defined:
  - A timeout counter increments each cycle in ACTIVE with no ack/err; it resets on any response or on leaving ACTIVE.
  - When it reaches TIMEOUT_CYCLES-1, the bridge enters FLUSH.
  - In FLUSH: wb_cyc_o = 0 (aborts the slave) and gnt_o = 0.
  - One rvalid_o = 1 with err_o = 1 and rdata_o = 0 is issued per cycle, decrementing the count, until it reaches 0; then the bridge returns to IDLE.
  - Wishbone ack/err inputs are ignored in FLUSH and do not set protocol_err_o.
- Not defined: no timeout counter or FLUSH state; the bridge waits indefinitely.

Test Plan:
- Single read, addr 0x0000_1004, slave acks after 3 cycles with 0xDEADBEEF -> wb_adr_o = 0x401; rvalid_o exactly 1 cycle after ack with rdata_o = 0xDEADBEEF, err_o = 0.
- Back-to-back requests, MAX_OUTSTANDING = 2, slave holds acks -> 2 grants, third req_i sees gnt_o = 0 and wb_stb_o = 0 until the first ack; responses arrive in order.
- wb_stall_i = 1 for 4 cycles on a write with be = 4'b0011 -> gnt_o = 0 for 4 cycles; wb_sel_o = 4'b0011 stable; grant on the first unstalled cycle; count becomes 1.
- Slave returns wb_err_i on a read -> rvalid_o = 1, err_o = 1, rdata_o = 0; the next read acks normally with err_o = 0.
- Spurious wb_ack_i with count = 0 -> no rvalid_o; protocol_err_o = 1 and stays set until rst_ni low.
- IBEX_WB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, 2 outstanding, no ack -> wb_cyc_o drops at cycle 16; two consecutive error rvalids; state IDLE; a new request is granted afterward.
